// File: rtl/soma_scan_ctrl.sv
// Per-tick neuron sweep: issues soma update/clear requests, captures fired indices
// into a first-word-fall-through FIFO. Optional spike counter: SOMA_SCAN_SPK_CNT_EN.
module soma_scan_ctrl #(
    parameter int NNW = 12,
    parameter int FDW = 4
) (
    input  logic           clk_soma,
    input  logic           rst,
    input  logic           tick,
    input  logic [NNW-1:0] neuron_num,
    input  logic           clear_mode,
    output logic           config_soma_vld,
    output logic [NNW-1:0] config_soma_vm_addr,
    output logic           config_soma_clear,
    input  logic           soma_spk_out_fire,
    output logic           spk_vld,
    output logic [NNW-1:0] spk_addr,
    input  logic           spk_rdy,
`ifdef SOMA_SCAN_SPK_CNT_EN
    output logic [NNW:0]   spk_cnt,
`endif
    output logic           scan_busy,
    output logic           scan_done,
    output logic           tick_miss
);
    localparam int DEPTH = 2**FDW;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t         state_q, state_d;
    logic [NNW-1:0] cnt_q, cnt_d;
    logic [NNW-1:0] last_q, last_d;
    logic           mode_q, mode_d;
    logic           vld_q, vld_d;
    logic [NNW-1:0] addr_q, addr_d;
    logic           clr_q, clr_d;

    logic           pvld_q, pclr_q;
    logic [NNW-1:0] paddr_q;

    logic [NNW-1:0] mem_q [DEPTH];
    logic [FDW-1:0] wptr_q, rptr_q;
    logic [FDW:0]   fcnt_q;

    logic [FDW+1:0] occ;
    logic           push, pop, slot_ok, accept;

    assign spk_vld             = (fcnt_q != '0);
    assign spk_addr            = mem_q[rptr_q];
    assign config_soma_vld     = vld_q;
    assign config_soma_vm_addr = addr_q;
    assign config_soma_clear   = clr_q;
    assign accept              = (state_q == IDLE) && tick;

    // Reserve room for the spike being pushed now and for the request already on the bus.
    always_comb begin
        push    = pvld_q && !pclr_q && soma_spk_out_fire;
        pop     = spk_vld && spk_rdy;
        occ     = {1'b0, fcnt_q}
                + {{(FDW+1){1'b0}}, push}
                + {{(FDW+1){1'b0}}, (vld_q && !clr_q)};
        slot_ok = (occ[FDW+1:FDW] == 2'b00);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        mode_d    = mode_q;
        vld_d     = 1'b0;
        addr_d    = addr_q;
        clr_d     = 1'b0;
        scan_busy = (state_q != IDLE);
        scan_done = 1'b0;
        tick_miss = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SCAN;
                    last_d  = neuron_num;
                    mode_d  = clear_mode;
                    cnt_d   = '0;
                    if (clear_mode || slot_ok) begin
                        vld_d  = 1'b1;
                        addr_d = '0;
                        clr_d  = clear_mode;
                        cnt_d  = NNW'(1);
                    end
                end
            end
            SCAN: begin
                tick_miss = tick;
                // Equality on the issued address, so the full-range sweep ends without wrapping.
                if (vld_q && (addr_q == last_q)) begin
                    state_d = DRAIN;
                end else if (mode_q || slot_ok) begin
                    vld_d  = 1'b1;
                    addr_d = cnt_q;
                    clr_d  = mode_q;
                    cnt_d  = cnt_q + NNW'(1);
                end
            end
            DRAIN: begin
                tick_miss = tick;
                scan_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_soma or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            mode_q  <= 1'b0;
            vld_q   <= 1'b0;
            addr_q  <= '0;
            clr_q   <= 1'b0;
            pvld_q  <= 1'b0;
            paddr_q <= '0;
            pclr_q  <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            mode_q  <= mode_d;
            vld_q   <= vld_d;
            addr_q  <= addr_d;
            clr_q   <= clr_d;
            pvld_q  <= vld_q;
            paddr_q <= addr_q;
            pclr_q  <= clr_q;
            if (push) wptr_q <= wptr_q + FDW'(1);
            if (pop)  rptr_q <= rptr_q + FDW'(1);
            case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + (FDW+1)'(1);
                2'b01:   fcnt_q <= fcnt_q - (FDW+1)'(1);
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_soma or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wptr_q] <= paddr_q;
        end
    end

`ifdef SOMA_SCAN_SPK_CNT_EN
    logic [NNW:0] spk_cnt_q;

    always_ff @(posedge clk_soma or posedge rst) begin
        if (rst)         spk_cnt_q <= '0;
        else if (accept) spk_cnt_q <= '0;
        else if (push)   spk_cnt_q <= spk_cnt_q + (NNW+1)'(1);
    end

    assign spk_cnt = spk_cnt_q;
`endif

endmodule

// File: tb/tb_soma_scan_ctrl.sv
// Bench for soma_scan_ctrl: directed sweep table, hand sequences for stall/miss/reset,
// and randomized sweeps checked against a sweep-level model with a spike queue.
module tb_soma_scan_ctrl;
    localparam int NNW   = 5;
    localparam int FDW   = 2;
    localparam int DEPTH = 4;

    logic           clk_soma = 1'b0;
    logic           rst, tick, clear_mode, soma_spk_out_fire, spk_rdy;
    logic [NNW-1:0] neuron_num;
    logic           config_soma_vld, config_soma_clear;
    logic [NNW-1:0] config_soma_vm_addr, spk_addr;
    logic           spk_vld, scan_busy, scan_done, tick_miss;
`ifdef SOMA_SCAN_SPK_CNT_EN
    logic [NNW:0]   spk_cnt;
`endif

    always #5 clk_soma = ~clk_soma;

    soma_scan_ctrl #(.NNW(NNW), .FDW(FDW)) dut (
        .clk_soma            (clk_soma),
        .rst                 (rst),
        .tick                (tick),
        .neuron_num          (neuron_num),
        .clear_mode          (clear_mode),
        .config_soma_vld     (config_soma_vld),
        .config_soma_vm_addr (config_soma_vm_addr),
        .config_soma_clear   (config_soma_clear),
        .soma_spk_out_fire   (soma_spk_out_fire),
        .spk_vld             (spk_vld),
        .spk_addr            (spk_addr),
        .spk_rdy             (spk_rdy),
`ifdef SOMA_SCAN_SPK_CNT_EN
        .spk_cnt             (spk_cnt),
`endif
        .scan_busy           (scan_busy),
        .scan_done           (scan_done),
        .tick_miss           (tick_miss)
    );

    int checks = 0;
    int failures = 0;

    // Sweep-level model: phase 0 idle, 1 requests outstanding, 2 last request seen.
    int          phase, exp_next, last_n, cyc;
    bit          mode, prev_vld, prev_clr, prev_issuing, prev_mode, next_fire;
    int          prev_addr, prev_qsize;
    int          q[$];
    int          mcnt, n_req, n_spk, n_done, n_miss, done_cyc, accept_cyc;
    int          fire_src;
    logic [31:0] fire_mask;

    typedef struct {
        int          n;
        bit          clr;
        int          src;
        logic [31:0] mask;
        int          exp_req;
        int          exp_spk;
        int          exp_ofs;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        phase = 0; exp_next = 0; last_n = 0; mode = 0;
        prev_vld = 0; prev_clr = 0; prev_addr = 0; prev_issuing = 0; prev_mode = 0;
        prev_qsize = 0; q.delete(); mcnt = 0; next_fire = 0;
        soma_spk_out_fire = 1'b0;
    endtask

    // One clock cycle: inputs already applied; sample at negedge, advance model, then step past posedge.
    task automatic step();
        int ph0;
        bit push, pop, exp_vld;
        @(negedge clk_soma);
        ph0 = phase;
        chk("scan_busy", scan_busy, ph0 != 0);
        chk("tick_miss", tick_miss, tick && (ph0 != 0));
        chk("scan_done", scan_done, ph0 == 2);
        if (scan_done) begin n_done++; done_cyc = cyc; end
        if (tick_miss) n_miss++;
        exp_vld = prev_issuing && (prev_mode || prev_qsize <= DEPTH - 3);
        if (exp_vld) chk("vld_no_stall", config_soma_vld, 1);
        if (config_soma_vld) begin
            n_req++;
            chk("vld_in_sweep", ph0 == 1, 1);
            chk("req_addr", config_soma_vm_addr, exp_next);
            chk("req_clear", config_soma_clear, mode);
        end
        chk("spk_vld", spk_vld, q.size() != 0);
        if (q.size() != 0) chk("spk_addr", spk_addr, q[0]);
`ifdef SOMA_SCAN_SPK_CNT_EN
        chk("spk_cnt", spk_cnt, mcnt);
`endif
        pop  = (q.size() != 0) && spk_rdy;
        push = prev_vld && !prev_clr && soma_spk_out_fire;
        prev_qsize = q.size();
        if (pop) void'(q.pop_front());
        if (push) begin q.push_back(prev_addr); mcnt++; n_spk++; end
        chk("fifo_overflow", q.size() > DEPTH, 0);
        case (fire_src)
            0:       next_fire = config_soma_vld && fire_mask[config_soma_vm_addr];
            1:       next_fire = 1'b1;
            default: next_fire = ($urandom_range(0, 1) == 1);
        endcase
        prev_vld  = config_soma_vld;
        prev_clr  = mode;
        prev_addr = exp_next;
        if (config_soma_vld && ph0 == 1) begin
            if (exp_next == last_n) phase = 2;
            else exp_next++;
        end
        if (ph0 == 2) phase = 0;
        if (ph0 == 0 && tick) begin
            phase = 1; exp_next = 0; last_n = int'(neuron_num); mode = clear_mode;
            mcnt = 0; n_req = 0; n_spk = 0; n_done = 0; n_miss = 0; accept_cyc = cyc;
        end
        prev_issuing = (phase == 1);
        prev_mode    = mode;
        @(posedge clk_soma);
        #1;
        cyc++;
        soma_spk_out_fire = next_fire;
    endtask

    task automatic run_sweep(input int n, input bit clr, input int src, input logic [31:0] mask,
                             input int rdy_mode, input int stray, input int miss_at);
        int guard;
        fire_src   = src;
        fire_mask  = mask;
        neuron_num = n[NNW-1:0];
        clear_mode = clr;
        tick       = 1'b1;
        spk_rdy    = (rdy_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
        step();
        tick       = 1'b0;
        neuron_num = NNW'($urandom);
        clear_mode = $urandom_range(0, 1) == 1;
        guard = 0;
        while (phase != 0 && guard < 400) begin
            spk_rdy = (rdy_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
            tick    = (guard == miss_at) || ((stray != 0) && ($urandom_range(0, stray - 1) == 0));
            step();
            guard++;
        end
        tick = 1'b0;
        chk("sweep_timeout", guard < 400, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{7,  1'b0, 0, 32'h0000_0024, 8,  2, 9};
        vecs[1] = '{3,  1'b1, 1, 32'h0000_0000, 4,  0, 5};
        vecs[2] = '{0,  1'b0, 1, 32'h0000_0000, 1,  1, 2};
        vecs[3] = '{31, 1'b0, 0, 32'h8000_0001, 32, 2, 33};
        vecs[4] = '{7,  1'b0, 0, 32'h0000_004A, 8,  3, 9};
        vecs[5] = '{5,  1'b0, 1, 32'h0000_0000, 6,  6, 7};

        cyc = 0; fire_src = 0; fire_mask = '0;
        n_req = 0; n_spk = 0; n_done = 0; n_miss = 0; done_cyc = 0; accept_cyc = 0;
        rst = 1'b1; tick = 1'b0; neuron_num = '0; clear_mode = 1'b0; spk_rdy = 1'b1;
        model_reset();
        #1;
        chk("rst_vld", config_soma_vld, 0);
        chk("rst_addr", config_soma_vm_addr, 0);
        chk("rst_clear", config_soma_clear, 0);
        chk("rst_spk_vld", spk_vld, 0);
        chk("rst_spk_addr", spk_addr, 0);
        chk("rst_busy", scan_busy, 0);
        chk("rst_done", scan_done, 0);
        chk("rst_miss", tick_miss, 0);
`ifdef SOMA_SCAN_SPK_CNT_EN
        chk("rst_spk_cnt", spk_cnt, 0);
`endif
        @(posedge clk_soma);
        @(posedge clk_soma);
        #1;
        rst = 1'b0;
        step();
        step();

        for (int i = 0; i < 6; i++) begin
            run_sweep(vecs[i].n, vecs[i].clr, vecs[i].src, vecs[i].mask, 1, 0, -1);
            chk($sformatf("v%0d_requests", i), n_req, vecs[i].exp_req);
            chk($sformatf("v%0d_spikes", i), n_spk, vecs[i].exp_spk);
            chk($sformatf("v%0d_done_ofs", i), done_cyc - accept_cyc, vecs[i].exp_ofs);
            chk($sformatf("v%0d_done_cnt", i), n_done, 1);
            $display("sweep v%0d n=%0d clr=%0d req=%0d spk=%0d done_ofs=%0d",
                     i, vecs[i].n, vecs[i].clr, n_req, n_spk, done_cyc - accept_cyc);
            step();
            step();
        end

        // Backpressure: FIFO fills and the sweep stalls until spk_rdy returns.
        fire_src = 1; neuron_num = 5'd9; clear_mode = 1'b0; spk_rdy = 1'b0; tick = 1'b1;
        step();
        tick = 1'b0;
        for (int k = 0; k < 12; k++) step();
        chk("stall_requests", n_req, 4);
        chk("stall_busy", scan_busy, 1);
        chk("stall_spk_vld", spk_vld, 1);
        chk("stall_head", spk_addr, 0);
        spk_rdy = 1'b1;
        for (int k = 0; k < 200 && phase != 0; k++) step();
        chk("stall_total_req", n_req, 10);
        chk("stall_total_spk", n_spk, 10);
        chk("stall_done_cnt", n_done, 1);
        for (int k = 0; k < 6; k++) step();
        chk("stall_drained", spk_vld, 0);
        $display("sweep stall req=%0d spk=%0d", n_req, n_spk);

        // Extra tick three cycles into a sweep.
        run_sweep(15, 1'b0, 0, 32'h0000_8001, 1, 0, 2);
        chk("miss_count", n_miss, 1);
        chk("miss_done_cnt", n_done, 1);
        chk("miss_requests", n_req, 16);
        chk("miss_done_ofs", done_cyc - accept_cyc, 17);
        $display("sweep tick_miss req=%0d misses=%0d", n_req, n_miss);
        step();

        // Reset in the middle of a sweep with two spikes queued.
        fire_src = 0; fire_mask = 32'h0000_0006; neuron_num = 5'd15; clear_mode = 1'b0;
        spk_rdy = 1'b0; tick = 1'b1;
        step();
        tick = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("pre_rst_vld", config_soma_vld, 1);
        chk("pre_rst_addr", config_soma_vm_addr, 4);
        chk("pre_rst_spk_vld", spk_vld, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", config_soma_vld, 0);
        chk("mid_rst_addr", config_soma_vm_addr, 0);
        chk("mid_rst_spk_vld", spk_vld, 0);
        chk("mid_rst_busy", scan_busy, 0);
`ifdef SOMA_SCAN_SPK_CNT_EN
        chk("mid_rst_spk_cnt", spk_cnt, 0);
`endif
        model_reset();
        spk_rdy = 1'b1;
        @(posedge clk_soma);
        @(posedge clk_soma);
        #1;
        rst = 1'b0;
        run_sweep(3, 1'b0, 0, 32'h0000_0001, 1, 0, -1);
        chk("post_rst_requests", n_req, 4);
        chk("post_rst_spikes", n_spk, 1);
        $display("sweep after reset req=%0d spk=%0d", n_req, n_spk);

        // Randomized sweeps: random length, mode, fire, backpressure and stray ticks.
        for (int s = 0; s < 30; s++) begin
            int n;
            bit clr;
            n   = (s % 10 == 9) ? 31 : int'($urandom_range(0, 31));
            clr = ($urandom_range(0, 3) == 0);
            run_sweep(n, clr, 2, 32'h0, 2, 20, -1);
            chk("rnd_requests", n_req, n + 1);
            chk("rnd_done_cnt", n_done, 1);
            $display("sweep rnd%0d n=%0d clr=%0d req=%0d spk=%0d misses=%0d",
                     s, n, clr, n_req, n_spk, n_miss);
            for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
                spk_rdy = ($urandom_range(0, 1) == 1);
                step();
            end
        end
        spk_rdy = 1'b1;
        for (int k = 0; k < 8; k++) step();
        chk("final_empty", spk_vld, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
